// File: rtl/vedic_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vedic_mul_arbiter (with vedic3bit)
// Brief    : Round-robin sharing of one 3x3 vedic multiplier between NREQ
//            requesters, with a valid/ready result port tagged by requester id.
// Revision : 1.0
// ============================================================================

module vedic3bit (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [5:0] p
);
  logic [1:0] w_col1;
  logic [1:0] w_col2;
  logic [1:0] w_col3;

  // Urdhva-tiryak (vertical and crosswise) column sums, then carry-resolved add
  assign w_col1 = 2'(a[1] & b[0]) + 2'(a[0] & b[1]);
  assign w_col2 = 2'(a[2] & b[0]) + 2'(a[1] & b[1]) + 2'(a[0] & b[2]);
  assign w_col3 = 2'(a[2] & b[1]) + 2'(a[1] & b[2]);
  assign p = 6'(a[0] & b[0]) + (6'(w_col1) << 1) + (6'(w_col2) << 2)
           + (6'(w_col3) << 3) + (6'(a[2] & b[2]) << 4);
endmodule

module vedic_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2*W-1:0]    res_data,
  output logic [IDW-1:0]    res_id,
  output logic              busy
);
  localparam logic [1:0]     C_IDLE     = 2'd0;
  localparam logic [1:0]     C_MUL      = 2'd1;
  localparam logic [1:0]     C_DONE     = 2'd2;
  localparam logic [IDW-1:0] C_LAST_RST = IDW'(NREQ - 1);

  logic [1:0]     r_state;
  logic [1:0]     w_state_nxt;
  logic [IDW-1:0] r_last;
  logic [IDW-1:0] r_id;
  logic [W-1:0]   r_op_a;
  logic [W-1:0]   r_op_b;
  logic [2*W-1:0] w_prod;
  logic           w_found;
  logic [IDW-1:0] w_win;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
    rr_idx = IDW'((int'(base) + off) % NREQ);
  endfunction

  // Scan from the farthest offset down so the nearest set bit after r_last wins
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[rr_idx(r_last, k)]) begin
        w_found = 1'b1;
        w_win   = rr_idx(r_last, k);
      end
    end
  end

  vedic3bit u_mul (
    .a (r_op_a),
    .b (r_op_b),
    .p (w_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= C_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_IDLE:  if (w_found) w_state_nxt = C_MUL;
      C_MUL:   w_state_nxt = C_DONE;
      C_DONE:  if (res_ready) w_state_nxt = C_IDLE;
      default: w_state_nxt = C_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != C_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last    <= C_LAST_RST;
      r_id      <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      gnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else begin
      case (r_state)
        C_IDLE: begin
          if (w_found) begin
            r_op_a <= a_in[W*int'(w_win) +: W];
            r_op_b <= b_in[W*int'(w_win) +: W];
            r_id   <= w_win;
            gnt    <= NREQ'(1) << w_win;
          end else begin
            gnt    <= '0;
          end
        end
        C_MUL: begin
          res_data  <= w_prod;
          res_id    <= r_id;
          res_valid <= 1'b1;
          gnt       <= '0;
        end
        C_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            r_last    <= r_id;
          end
        end
        default: gnt <= '0;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_vedic_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vedic_mul_arbiter
// Brief    : Scoreboard bench for the round-robin shared vedic multiplier.
// Revision : 1.0
// ============================================================================
module tb_vedic_mul_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic              res_valid;
  logic              res_ready;
  logic [2*W-1:0]    res_data;
  logic [IDW-1:0]    res_id;
  logic              busy;

  typedef struct {
    int         id;
    logic [5:0] data;
  } exp_t;

  exp_t sb[$];
  int   glog_id[$];
  int   glog_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;
  exp_t mon_e;

  vedic_mul_arbiter #(.NREQ(NREQ), .IDW(IDW), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: logs grants and scores every accepted result against the queue
  always @(negedge clk) begin
    if (mon_en) begin
      if (gnt != '0) begin
        checks++;
        if ($countones(gnt) != 1) begin
          errors++;
          $display("FAIL gnt_onehot: got %b, required exactly one bit", gnt);
        end
        for (int i = 0; i < NREQ; i++) if (gnt[i]) glog_id.push_back(i);
        glog_cyc.push_back(cyc);
      end
      if (res_valid && res_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL result_unexpected: got id=%0d data=%0d, required none", res_id, res_data);
        end else begin
          mon_e = sb.pop_front();
          if (res_id !== IDW'(mon_e.id) || res_data !== mon_e.data) begin
            errors++;
            $display("FAIL result: got id=%0d data=%0d, required id=%0d data=%0d",
                     res_id, res_data, mon_e.id, mon_e.data);
          end
        end
      end
    end
  end

  task automatic push_exp(input int idx, input logic [2:0] a, input logic [2:0] b);
    exp_t e;
    e.id   = idx;
    e.data = {3'b000, a} * {3'b000, b};
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending results, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  // One complete transaction from requester idx with res_ready held high
  task automatic issue(input int idx, input logic [2:0] a, input logic [2:0] b);
    int n = 0;
    @(posedge clk); #1;
    req[idx] = 1'b1;
    a_in[W*idx +: W] = a;
    b_in[W*idx +: W] = b;
    push_exp(idx, a, b);
    do begin
      @(negedge clk);
      n++;
    end while (gnt[idx] !== 1'b1 && n < 50);
    checks++;
    if (gnt !== NREQ'(1) << idx) begin
      errors++;
      $display("FAIL issue_gnt: got %b, required %b", gnt, NREQ'(1) << idx);
    end
    @(posedge clk); #1;
    req[idx] = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || gnt !== '0) begin
      errors++;
      $display("FAIL issue_timing: got valid=%b gnt=%b, required valid=1 gnt=0", res_valid, gnt);
    end
    wait_drain("issue");
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req = '0; a_in = '0; b_in = '0; res_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== '0 || res_valid !== 1'b0 || res_data !== '0 || res_id !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: got gnt=%b valid=%b data=%0d id=%0d busy=%b, required all 0",
               gnt, res_valid, res_data, res_id, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b gnt=%b, required 0", busy, gnt);
    end
  endtask

  task automatic test_round_robin();
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    int n;
    glog_id.delete(); glog_cyc.delete();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      a_in[W*i +: W] = 3'(i + 4);
      b_in[W*i +: W] = 3'(i + 3);
    end
    req = '1;
    for (int g = 0; g < 5; g++) push_exp(exp_ord[g], 3'(exp_ord[g] + 4), 3'(exp_ord[g] + 3));
    for (int g = 0; g < 5; g++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (gnt === '0 && n < 20);
    end
    @(posedge clk); #1;
    req = '0;
    wait_drain("rr");
    checks++;
    if (glog_id.size() != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d grants, required 5", glog_id.size());
    end else begin
      for (int g = 0; g < 5; g++) begin
        checks++;
        if (glog_id[g] != exp_ord[g]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got %0d, required %0d", g, glog_id[g], exp_ord[g]);
        end
        if (g > 0) begin
          checks++;
          if (glog_cyc[g] - glog_cyc[g-1] != 3) begin
            errors++;
            $display("FAIL rr_rate[%0d]: got %0d cycles, required 3", g, glog_cyc[g] - glog_cyc[g-1]);
          end
        end
      end
    end
  endtask

  task automatic test_basic();
    issue(0, 3'd1, 3'd2);
  endtask

  task automatic test_sequence();
    logic [2:0] av[4] = '{3'd2, 3'd4, 3'd5, 3'd6};
    logic [2:0] bv[4] = '{3'd4, 3'd5, 3'd6, 3'd7};
    for (int i = 0; i < 4; i++) issue(2, av[i], bv[i]);
  endtask

  task automatic test_backpressure();
    int n = 0;
    @(posedge clk); #1;
    res_ready = 1'b0;
    req[1] = 1'b1; a_in[W*1 +: W] = 3'd3; b_in[W*1 +: W] = 3'd5;
    push_exp(1, 3'd3, 3'd5);
    do begin
      @(negedge clk);
      n++;
    end while (gnt[1] !== 1'b1 && n < 50);
    @(posedge clk); #1;
    req[1] = 1'b0;
    req[3] = 1'b1; a_in[W*3 +: W] = 3'd2; b_in[W*3 +: W] = 3'd6;
    push_exp(3, 3'd2, 3'd6);
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== 6'd15 || res_id !== 2'd1 || gnt !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold: got valid=%b data=%0d id=%0d gnt=%b busy=%b, required 1 15 1 0000 1",
                 res_valid, res_data, res_id, gnt, busy);
      end
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got busy=%b valid=%b, required 0 0", busy, res_valid);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt[3] !== 1'b1 && n < 50);
    @(posedge clk); #1;
    req[3] = 1'b0;
    wait_drain("bp");
  endtask

  task automatic test_corners();
    issue(1, 3'd0, 3'd7);
    issue(2, 3'd7, 3'd7);
    issue(3, 3'd1, 3'd1);
    @(posedge clk); #1;
    req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (gnt !== '0 || res_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL dropped_req: got gnt=%b valid=%b busy=%b, required 0", gnt, res_valid, busy);
      end
    end
  endtask

  task automatic test_reset_abort();
    int n = 0;
    @(posedge clk); #1;
    req[2] = 1'b1; a_in[W*2 +: W] = 3'd5; b_in[W*2 +: W] = 3'd5;
    do begin
      @(negedge clk);
      n++;
    end while (gnt[2] !== 1'b1 && n < 50);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== '0 || res_valid !== 1'b0 || res_data !== '0 || res_id !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: got gnt=%b valid=%b data=%0d id=%0d busy=%b, required all 0",
               gnt, res_valid, res_data, res_id, busy);
    end
    req = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    glog_id.delete(); glog_cyc.delete();
    issue(3, 3'd3, 3'd3);
    checks++;
    if (glog_id.size() != 1 || glog_id[0] != 3) begin
      errors++;
      $display("FAIL abort_regrant: got %0d grants (first %0d), required one grant to 3",
               glog_id.size(), (glog_id.size() > 0) ? glog_id[0] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_basic();
    test_sequence();
    test_backpressure();
    test_corners();
    test_reset_abort();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule

`default_nettype wire
